alu_md: RTL and testbench

- Parametrised, registered successor to the combinational MIPS ALU.
- Executes single-cycle integer ops with a 1-cycle registered result.
- Adds an iterative multiply/divide engine with architectural HI/LO registers, plus MFHI/MFLO reads.
- Sits in the EX stage; the issue side uses an in_valid/in_ready handshake, and the result side emits an out_valid pulse.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_md_if.sv | 28 ++
 rtl/md_unit.sv | 127 ++++++++++++
 rtl/alu_md.sv | 113 +++++++++++
 tb/tb_alu_md.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, mul/div state encoding and decode helpers for the alu_md EX-stage unit.
package alu_pkg;

  typedef enum logic [4:0] {
    OpAdd   = 5'd0,
    OpSub   = 5'd1,
    OpAnd   = 5'd2,
    OpOr    = 5'd3,
    OpSll   = 5'd4,
    OpSrl   = 5'd5,
    OpSra   = 5'd6,
    OpLui   = 5'd7,
    OpSlt   = 5'd8,
    OpSltu  = 5'd9,
    OpXor   = 5'd10,
    OpNor   = 5'd11,
    OpMult  = 5'd12,
    OpMultu = 5'd13,
    OpDiv   = 5'd14,
    OpDivu  = 5'd15,
    OpMfhi  = 5'd16,
    OpMflo  = 5'd17
  } op_t;

  localparam logic [4:0] OP_MD_FIRST = 5'd12;
  localparam logic [4:0] OP_MD_LAST  = 5'd15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } md_state_t;

  function automatic logic op_is_md(input logic [4:0] op);
    return (op >= OP_MD_FIRST) && (op <= OP_MD_LAST);
  endfunction

endpackage

// File: rtl/alu_md_if.sv
// Issue/result bundle between the EX-stage issuer (master) and alu_md (slave).
interface alu_md_if #(
  parameter int unsigned WIDTH = 32
) ();
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, op, a, b, shamt,
    input  in_ready, out_valid, result, zero, overflow, busy
  );

  modport slave (
    input  in_valid, op, a, b, shamt,
    output in_ready, out_valid, result, zero, overflow, busy
  );
endinterface

// File: rtl/md_unit.sv
// Iterative multiply/divide engine: magnitude shift-add / restoring divide, then sign fix-up
// into the architectural HI/LO pair. kind[1] selects divide, kind[0] selects unsigned.
module md_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       kind,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fix,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] lo_fix
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned W2  = 2 * WIDTH;

  md_state_t        state_q;
  logic [SHW-1:0]   count_q;
  logic [W2-1:0]    p_q;       // {partial hi / remainder, multiplier / quotient}
  logic [WIDTH-1:0] d_q;       // multiplicand or divisor magnitude
  logic             is_div_q;
  logic             neg_q;
  logic             rem_neg_q;
  logic             div_zero_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] hi_fix;

  always_comb begin
    a_neg = ~kind[0] & a[WIDTH-1];
    b_neg = ~kind[0] & b[WIDTH-1];
    a_mag = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag = b_neg ? (~b + WIDTH'(1)) : b;

    mul_sum  = {1'b0, p_q[W2-1:WIDTH]} + {1'b0, d_q};
    mul_next = p_q[0] ? {mul_sum, p_q[WIDTH-1:1]} : {1'b0, p_q[W2-1:1]};

    div_sh   = {p_q[W2-1:WIDTH], p_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, d_q};
    div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

    prod_fix = neg_q ? (~p_q + W2'(1)) : p_q;
    quo_fix  = neg_q ? (~p_q[WIDTH-1:0] + WIDTH'(1)) : p_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? (~p_q[W2-1:WIDTH] + WIDTH'(1)) : p_q[W2-1:WIDTH];

    // Divide by zero is not trapped: quotient saturates to all ones, remainder is the dividend.
    if (is_div_q) begin
      lo_fix = div_zero_q ? '1 : quo_fix;
      hi_fix = rem_fix;
    end else begin
      lo_fix = prod_fix[WIDTH-1:0];
      hi_fix = prod_fix[W2-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      p_q        <= '0;
      d_q        <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            p_q        <= {{WIDTH{1'b0}}, a_mag};
            d_q        <= b_mag;
            is_div_q   <= kind[1];
            neg_q      <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            div_zero_q <= (b == '0);
            count_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          p_q     <= is_div_q ? div_next : mul_next;
          count_q <= count_q + 1'b1;
          if (count_q == SHW'(WIDTH - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign fix  = (state_q == StFix);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: rtl/alu_md.sv
// Registered EX-stage ALU: single-cycle integer ops plus HI/LO moves, with an attached
// iterative mul/div engine that blocks issue while it runs.
module alu_md
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_md_if.slave  bus
);
  logic             accept;
  logic             is_md;
  logic             md_busy;
  logic             md_fix;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_lo_fix;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_ovf;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             out_valid_q;

  assign bus.in_ready = ~md_busy;
  assign accept       = bus.in_valid & ~md_busy;
  assign is_md        = op_is_md(bus.op);

  md_unit #(
    .WIDTH (WIDTH)
  ) u_md_unit (
    .clk    (clk),
    .reset  (reset),
    .start  (accept & is_md),
    .kind   (bus.op[1:0]),
    .a      (bus.a),
    .b      (bus.b),
    .busy   (md_busy),
    .fix    (md_fix),
    .hi     (md_hi),
    .lo     (md_lo),
    .lo_fix (md_lo_fix)
  );

  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpAnd:  alu_res = bus.a & bus.b;
      OpOr:   alu_res = bus.a | bus.b;
      OpXor:  alu_res = bus.a ^ bus.b;
      OpNor:  alu_res = ~(bus.a | bus.b);
      OpSll:  alu_res = bus.b << bus.shamt;
      OpSrl:  alu_res = bus.b >> bus.shamt;
      OpSra:  alu_res = $signed(bus.b) >>> bus.shamt;
      OpLui:  alu_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OpMfhi: alu_res = md_hi;
      OpMflo: alu_res = md_lo;
      default: alu_res = '0;
    endcase
    // For SUB this is also the a == b branch indicator.
    alu_zero = (alu_res == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (md_fix) begin
        result_q    <= md_lo_fix;
        zero_q      <= 1'b0;
        overflow_q  <= 1'b0;
        out_valid_q <= 1'b1;
      end else if (accept && !is_md) begin
        result_q    <= alu_res;
        zero_q      <= alu_zero;
        overflow_q  <= alu_ovf;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        zero_q      <= 1'b0;
        overflow_q  <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = md_busy;
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: single-cycle vector table, then mul/div, reset and pipelining
// sequences with hand-computed expectations.
module tb_alu_md;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  alu_md_if #(.WIDTH(32)) bus ();

  alu_md #(
    .WIDTH (32)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.shamt    = sh;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [31:0] res, input logic z,
                           input logic o);
    check({name, ".valid"}, 64'(bus.out_valid), 64'd1);
    check({name, ".result"}, 64'(bus.result), 64'(res));
    check({name, ".zero"}, 64'(bus.zero), 64'(z));
    check({name, ".ovf"}, 64'(bus.overflow), 64'(o));
  endtask

  task automatic run_md(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cycles;
    int low;
    cycles = 0;
    low    = 0;
    issue(op, a, b, 5'd0);
    while (!bus.out_valid && cycles < 100) begin
      if (!bus.in_ready) low++;
      @(posedge clk);
      #1;
      cycles++;
    end
    check({name, ".latency"}, 64'(cycles), 64'd33);
    check({name, ".stall"}, 64'(low), 64'd33);
    check_out({name, ".lo"}, exp_lo, 1'b0, 1'b0);
    check({name, ".busy"}, 64'(bus.busy), 64'd0);
    check({name, ".ready"}, 64'(bus.in_ready), 64'd1);
    // MFHI issued in the out_valid cycle must see the freshly written HI.
    issue(OpMfhi, 32'd0, 32'd0, 5'd0);
    check_out({name, ".mfhi"}, exp_hi, (exp_hi == 32'd0), 1'b0);
  endtask

  initial begin
    int pulses;
    n_cmp        = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = 5'd0;
    bus.a        = '0;
    bus.b        = '0;
    bus.shamt    = '0;

    vq.push_back('{OpAdd,   32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1});
    vq.push_back('{OpSub,   32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1, 1'b0});
    vq.push_back('{OpSub,   32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1});
    vq.push_back('{OpAdd,   32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0});
    vq.push_back('{OpAnd,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0, 1'b0});
    vq.push_back('{OpOr,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hFFF0_FFF0, 1'b0, 1'b0});
    vq.push_back('{OpXor,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h0FF0_0FF0, 1'b0, 1'b0});
    vq.push_back('{OpNor,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h000F_000F, 1'b0, 1'b0});
    vq.push_back('{OpSll,   32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0});
    vq.push_back('{OpSrl,   32'h0000_0000, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0});
    vq.push_back('{OpSra,   32'h0000_0000, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0});
    vq.push_back('{OpSra,   32'h0000_0000, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 1'b0});
    vq.push_back('{OpLui,   32'h0000_0000, 32'hABCD_1234, 5'd0,  32'h1234_0000, 1'b0, 1'b0});
    vq.push_back('{OpSlt,   32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0});
    vq.push_back('{OpSltu,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0});
    vq.push_back('{5'd20,   32'h0000_0005, 32'h0000_0006, 5'd0,  32'h0000_0000, 1'b1, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst.ready", 64'(bus.in_ready), 64'd1);
    check("rst.valid", 64'(bus.out_valid), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.result", 64'(bus.result), 64'd0);
    check("rst.zero", 64'(bus.zero), 64'd0);
    check("rst.ovf", 64'(bus.overflow), 64'd0);

    foreach (vq[i]) begin
      issue(vq[i].op, vq[i].a, vq[i].b, vq[i].sh);
      check_out($sformatf("vec%0d", i), vq[i].res, vq[i].z, vq[i].o);
    end
    @(posedge clk);
    #1;
    check("vec.pulse_end", 64'(bus.out_valid), 64'd0);

    // Reset in the same cycle as a request: the op is dropped.
    issue(OpAdd, 32'd7, 32'd8, 5'd0);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = OpAdd;
    bus.a        = 32'd1;
    bus.b        = 32'd1;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("rstop.valid", 64'(bus.out_valid), 64'd0);
    check("rstop.result", 64'(bus.result), 64'd0);
    @(posedge clk);
    #1;
    check("rstop.dropped", 64'(bus.out_valid), 64'd0);

    run_md("mult", OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("div", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu0", OpDivu, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run_md("divovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_md("multu", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(OpMflo, 32'd0, 32'd0, 5'd0);
    check_out("multu.mflo", 32'h0000_0001, 1'b0, 1'b0);

    // Abort an in-flight MULTU with reset; HI/LO must read back cleared.
    issue(OpMultu, 32'hFFFF_FFFF, 32'd2, 5'd0);
    check("abort.busy_on", 64'(bus.busy), 64'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.ready", 64'(bus.in_ready), 64'd1);
    check("abort.valid", 64'(bus.out_valid), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) pulses++;
    end
    check("abort.no_pulse", 64'(pulses), 64'd0);
    issue(OpMflo, 32'd0, 32'd0, 5'd0);
    check_out("abort.mflo", 32'd0, 1'b1, 1'b0);
    issue(OpMfhi, 32'd0, 32'd0, 5'd0);
    check_out("abort.mfhi", 32'd0, 1'b1, 1'b0);

    // Back-to-back issue: ADD, XOR, LUI on consecutive edges.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = OpAdd;
    bus.a        = 32'd1;
    bus.b        = 32'd2;
    @(posedge clk);
    #1;
    check_out("b2b.add", 32'd3, 1'b0, 1'b0);
    bus.op = OpXor;
    bus.a  = 32'h0000_00FF;
    bus.b  = 32'h0000_000F;
    @(posedge clk);
    #1;
    check_out("b2b.xor", 32'h0000_00F0, 1'b0, 1'b0);
    bus.op = OpLui;
    bus.b  = 32'h0000_1234;
    @(posedge clk);
    #1;
    check_out("b2b.lui", 32'h1234_0000, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b.end", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
